// File: rtl/div_ctrl_pkg.sv
// Shared reset level and FSM encoding for the EX-stage divide controller.
package div_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage divide controller: stalls the pipeline, feeds the external divider, writes HI/LO,
// short-circuits divide-by-zero and aborts a divide that never completes.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 36,
    parameter int unsigned WDOG_SLACK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_div_req,
    input  logic        ex_flag_unsigned,
    input  logic [31:0] ex_operand1,
    input  logic [31:0] ex_operand2,
    input  logic        flush,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_flag_unsigned,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_done,
    input  logic [63:0] div_result,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy,
    output logic        div_err
);

    localparam int unsigned WdogLimit = DIV_CYCLES + WDOG_SLACK;
    localparam int unsigned WdogW     = $clog2(WdogLimit + 1);

    div_state_e        state_q;
    logic [WdogW-1:0]  wdog_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic              unsigned_q;
    logic              wdog_timeout;

    // wdog_q holds the number of completed RUN cycles, so this fires in RUN cycle WdogLimit.
    assign wdog_timeout = (wdog_q == WdogW'(WdogLimit - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RST_ENABLE) begin
            state_q    <= StIdle;
            wdog_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            unsigned_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ex_div_req && !flush) begin
                        if (ex_operand2 != '0) begin
                            op1_q      <= ex_operand1;
                            op2_q      <= ex_operand2;
                            unsigned_q <= ex_flag_unsigned;
                            wdog_q     <= '0;
                            state_q    <= StRun;
                        end else begin
                            hi_q    <= ex_operand1;
                            lo_q    <= '1;
                            state_q <= StDone;
                        end
                    end
                end
                StRun: begin
                    // Flush outranks a coincident done; the result is discarded.
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (div_done) begin
                        hi_q    <= div_result[63:32];
                        lo_q    <= div_result[31:0];
                        state_q <= StDone;
                    end else if (wdog_timeout) begin
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + WdogW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy              = (state_q != StIdle);
    assign div_start         = (state_q == StRun);
    assign div_flag_unsigned = unsigned_q;
    assign div_op1           = op1_q;
    assign div_op2           = op2_q;
    assign hi_o              = hi_q;
    assign lo_o              = lo_q;
    assign hilo_we           = (state_q == StDone) && !flush;
    assign div_err           = (state_q == StRun) && !flush && !div_done && wdog_timeout;

    // Gated by reset so the stall drops with reset even while EX still presents a request.
    assign stall_req = (reset != RST_ENABLE) &&
                       (((state_q == StIdle) && ex_div_req && !flush) || (state_q == StRun));

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency divider beside it.
module tb_div_ctrl;

    localparam int unsigned DivCycles = 36;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_div_req;
    logic        ex_flag_unsigned;
    logic [31:0] ex_operand1;
    logic [31:0] ex_operand2;
    logic        flush;
    logic        stall_req;
    logic        div_start;
    logic        div_flag_unsigned;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_done;
    logic [63:0] div_result;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        div_err;

    logic        done_en;
    logic        force_done;
    int unsigned mcnt;
    logic [31:0] mq;
    logic [31:0] mr;

    int checks   = 0;
    int failures = 0;

    div_ctrl #(
        .DIV_CYCLES(DivCycles),
        .WDOG_SLACK(4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ex_div_req       (ex_div_req),
        .ex_flag_unsigned (ex_flag_unsigned),
        .ex_operand1      (ex_operand1),
        .ex_operand2      (ex_operand2),
        .flush            (flush),
        .stall_req        (stall_req),
        .div_start        (div_start),
        .div_flag_unsigned(div_flag_unsigned),
        .div_op1          (div_op1),
        .div_op2          (div_op2),
        .div_done         (div_done),
        .div_result       (div_result),
        .hilo_we          (hilo_we),
        .hi_o             (hi_o),
        .lo_o             (lo_o),
        .busy             (busy),
        .div_err          (div_err)
    );

    always #5 clock = ~clock;

    // Divider stand-in: done in the (DivCycles+1)-th cycle of a continuous start level.
    always @(posedge clock or negedge reset) begin
        if (!reset)         mcnt <= 0;
        else if (div_start) mcnt <= mcnt + 1;
        else                mcnt <= 0;
    end

    always_comb begin
        mq = '0;
        mr = '0;
        if (div_op2 != '0) begin
            if (div_flag_unsigned) begin
                mq = div_op1 / div_op2;
                mr = div_op1 % div_op2;
            end else begin
                mq = $signed(div_op1) / $signed(div_op2);
                mr = $signed(div_op1) % $signed(div_op2);
            end
        end
    end

    assign div_result = {mr, mq};
    assign div_done   = force_done | (done_en & div_start & (mcnt == DivCycles));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue a divide in the current IDLE cycle and follow it to its DONE cycle.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic u, input logic [31:0] eh, input logic [31:0] el,
                           input int lat);
        int  cyc;
        bit  seen;
        ex_div_req       = 1'b1;
        ex_flag_unsigned = u;
        ex_operand1      = a;
        ex_operand2      = b;
        #1;
        chk({tag, "_stall_c0"}, 64'(stall_req), 64'(1));
        chk({tag, "_start_c0"}, 64'(div_start), 64'(0));
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if (hilo_we) begin
                seen = 1;
            end else begin
                chk({tag, "_stall_run"}, 64'(stall_req), 64'(1));
                chk({tag, "_start_run"}, 64'(div_start), 64'(b != 0));
                chk({tag, "_op1_run"}, 64'(div_op1), 64'(a));
            end
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_hi"}, 64'(hi_o), 64'(eh));
        chk({tag, "_lo"}, 64'(lo_o), 64'(el));
        chk({tag, "_stall_done"}, 64'(stall_req), 64'(0));
        chk({tag, "_start_done"}, 64'(div_start), 64'(0));
        ex_div_req = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        ex_div_req       = 1'b0;
        ex_flag_unsigned = 1'b0;
        ex_operand1      = '0;
        ex_operand2      = '0;
        flush            = 1'b0;
        done_en          = 1'b1;
        force_done       = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_start", 64'(div_start), 64'(0));
        chk("rst_stall", 64'(stall_req), 64'(0));
        chk("rst_hilo_we", 64'(hilo_we), 64'(0));
        chk("rst_err", 64'(div_err), 64'(0));
        chk("rst_hi", 64'(hi_o), 64'(0));
        chk("rst_lo", 64'(lo_o), 64'(0));
        chk("rst_op2", 64'(div_op2), 64'(0));
        reset = 1'b1;
        tick();

        run_div("div_100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 38);
        tick();
        chk("after_done_busy", 64'(busy), 64'(0));
        chk("after_done_we", 64'(hilo_we), 64'(0));

        // Back-to-back: second request in the IDLE cycle right after DONE.
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 38);
        tick();
        run_div("divu_max_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'h7FFF_FFFF, 38);
        tick();

        run_div("div_5_0", 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1);
        tick();

        // Flush in RUN cycle 10.
        ex_div_req  = 1'b1;
        ex_operand1 = 32'd50;
        ex_operand2 = 32'd5;
        repeat (10) tick();
        flush = 1'b1;
        #1;
        chk("flush_c10_start", 64'(div_start), 64'(1));
        chk("flush_c10_we", 64'(hilo_we), 64'(0));
        tick();
        flush      = 1'b0;
        ex_div_req = 1'b0;
        #1;
        chk("flush_c11_busy", 64'(busy), 64'(0));
        chk("flush_c11_start", 64'(div_start), 64'(0));
        chk("flush_c11_we", 64'(hilo_we), 64'(0));
        chk("flush_c11_lo", 64'(lo_o), 64'(32'hFFFF_FFFF));
        tick();
        run_div("div_1000_33", 32'd1000, 32'd33, 1'b0, 32'd10, 32'd30, 38);
        tick();

        // Flush coinciding with div_done.
        ex_div_req  = 1'b1;
        ex_operand1 = 32'd77;
        ex_operand2 = 32'd7;
        repeat (37) tick();
        chk("fd_done_seen", 64'(div_done), 64'(1));
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        ex_div_req = 1'b0;
        #1;
        chk("fd_busy", 64'(busy), 64'(0));
        chk("fd_we", 64'(hilo_we), 64'(0));
        chk("fd_hi", 64'(hi_o), 64'(10));
        chk("fd_lo", 64'(lo_o), 64'(30));
        tick();

        // Stray done in IDLE.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        #1;
        chk("stray_busy", 64'(busy), 64'(0));
        chk("stray_we", 64'(hilo_we), 64'(0));
        chk("stray_lo", 64'(lo_o), 64'(30));
        tick();

        // Watchdog: divider never completes.
        done_en     = 1'b0;
        ex_div_req  = 1'b1;
        ex_operand1 = 32'd9;
        ex_operand2 = 32'd3;
        repeat (39) tick();
        chk("wd_c39_err", 64'(div_err), 64'(0));
        chk("wd_c39_busy", 64'(busy), 64'(1));
        tick();
        chk("wd_c40_err", 64'(div_err), 64'(1));
        chk("wd_c40_we", 64'(hilo_we), 64'(0));
        tick();
        ex_div_req = 1'b0;
        #1;
        chk("wd_c41_busy", 64'(busy), 64'(0));
        chk("wd_c41_err", 64'(div_err), 64'(0));
        chk("wd_c41_we", 64'(hilo_we), 64'(0));
        chk("wd_c41_hi", 64'(hi_o), 64'(10));
        done_en = 1'b1;
        tick();

        // Asynchronous reset mid-RUN with the request still held.
        ex_div_req  = 1'b1;
        ex_operand1 = 32'd200;
        ex_operand2 = 32'd3;
        repeat (5) tick();
        chk("mid_start_pre", 64'(div_start), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_start", 64'(div_start), 64'(0));
        chk("mid_rst_stall", 64'(stall_req), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_hi", 64'(hi_o), 64'(0));
        chk("mid_rst_lo", 64'(lo_o), 64'(0));
        chk("mid_rst_op1", 64'(div_op1), 64'(0));
        ex_div_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
